// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: NUM_REQ requesters onto 2 register-file write ports.
// 1-cycle latency; req_ready is a combinational grant, ungranted requesters hold and retry.
module wb_arbiter #(
   parameter int SIZE    = 32,
   parameter int REG_NUM = 8,
   parameter int NUM_REQ = 4
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [NUM_REQ-1:0]                        req_valid,
   input  logic [NUM_REQ-1:0][$clog2(REG_NUM)-1:0]   req_reg,
   input  logic [NUM_REQ-1:0][SIZE-1:0]              req_data,
   output logic [NUM_REQ-1:0]                        req_ready,
   output logic [1:0]                                RegWrite,
   output logic [1:0][$clog2(REG_NUM)-1:0]           write_reg,
   output logic [1:0][SIZE-1:0]                      write_data,
   output logic [REG_NUM-1:0]                        pending
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [PW:0] NREQ = (PW+1)'(NUM_REQ);

   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] next_ptr;
   logic [PW-1:0] g0_idx;
   logic [PW-1:0] g1_idx;
   logic          g0_vld;
   logic          g1_vld;

   // Port 1 skips any requester targeting port 0's register so both ports never collide.
   always_comb begin : scan
      logic [PW:0] pos;
      logic [PW:0] nxt;
      pos    = '0;
      nxt    = '0;
      g0_vld = 1'b0;
      g1_vld = 1'b0;
      g0_idx = '0;
      g1_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = {1'b0, rr_ptr} + (PW+1)'(k);
         if (pos >= NREQ) pos = pos - NREQ;
         if (req_valid[pos[PW-1:0]]) begin
            if (!g0_vld) begin
               g0_vld = 1'b1;
               g0_idx = pos[PW-1:0];
            end else if (!g1_vld && (req_reg[pos[PW-1:0]] != req_reg[g0_idx])) begin
               g1_vld = 1'b1;
               g1_idx = pos[PW-1:0];
            end
         end
      end
      nxt = {1'b0, (g1_vld ? g1_idx : g0_idx)} + (PW+1)'(1);
      if (nxt >= NREQ) nxt = nxt - NREQ;
      next_ptr = nxt[PW-1:0];
   end

   always_comb begin
      req_ready = '0;
      if (rst_n) begin
         if (g0_vld) req_ready[g0_idx] = 1'b1;
         if (g1_vld) req_ready[g1_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr     <= '0;
         RegWrite   <= '0;
         write_reg  <= '0;
         write_data <= '0;
      end else begin
         RegWrite <= {g1_vld, g0_vld};
         if (g0_vld) begin
            write_reg[0]  <= req_reg[g0_idx];
            write_data[0] <= req_data[g0_idx];
            rr_ptr        <= next_ptr;
         end
         if (g1_vld) begin
            write_reg[1]  <= req_reg[g1_idx];
            write_data[1] <= req_data[g1_idx];
         end
      end
   end

   always_comb begin
      pending = '0;
      for (int p = 0; p < 2; p++) begin
         if (RegWrite[p]) pending[write_reg[p]] = 1'b1;
      end
   end

endmodule
